// File: rtl/dmem_responder_if.sv
// Request/response bus between a CPU data port and the memory responder.
// The master drives the request; the slave answers with busy/ready/rdata/err.
interface dmem_responder_if #(
    parameter int n = 32
);
    logic         req;
    logic         we;
    logic [2:0]   funct3;
    logic [n-1:0] addr;
    logic [n-1:0] wdata;
    logic         busy;
    logic         ready;
    logic [n-1:0] rdata;
    logic         err;

    modport master (
        output req, we, funct3, addr, wdata,
        input  busy, ready, rdata, err
    );

    modport slave (
        input  req, we, funct3, addr, wdata,
        output busy, ready, rdata, err
    );
endinterface

// File: rtl/dmem_responder.sv
// Wait-stated data memory responder: one request at a time, RISC-V byte/half/word
// lane handling with sign/zero extension, misalignment and bad-funct3 faults.
module dmem_responder #(
    parameter int n     = 32,
    parameter int DEPTH = 256,
    parameter int WAIT  = 2
) (
    input  logic              clock,
    input  logic              reset,
    dmem_responder_if.slave   bus
);
    localparam int         AW        = $clog2(DEPTH);
    localparam logic       HAS_WAIT  = (WAIT > 0);
    localparam logic [3:0] WAIT_LAST = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [3:0]     cnt_r;
    logic [3:0]     cnt_nxt_s;
    logic           accept_s;
    logic           commit_s;

    logic           we_r;
    logic [2:0]     f3_r;
    logic [n-1:0]   addr_r;
    logic [n-1:0]   wdata_r;

    logic           busy_r;
    logic           ready_r;
    logic           err_r;
    logic [n-1:0]   rdata_r;

    logic [n-1:0]   mem_r [DEPTH];
    logic [AW-1:0]  idx_s;
    logic           fault_s;
    logic [n-1:0]   word_s;
    logic [n-AW-3:0] addr_unused_s;

    // Access legality for a given direction, size code and byte offset.
    function automatic logic access_fault(input logic st, input logic [2:0] f3,
                                          input logic [1:0] lane);
        logic f;
        case (f3)
            3'b000:  f = 1'b0;
            3'b001:  f = lane[0];
            3'b010:  f = (lane != 2'b00);
            3'b100:  f = st;
            3'b101:  f = st | lane[0];
            default: f = 1'b1;
        endcase
        return f;
    endfunction

    // Extract the addressed lane(s) and extend to full width.
    function automatic logic [n-1:0] load_ext(input logic [n-1:0] word,
                                              input logic [1:0] lane,
                                              input logic [2:0] f3);
        logic [n-1:0] sh;
        logic [n-1:0] res;
        sh = word >> {lane, 3'b000};
        case (f3)
            3'b000:  res = {{(n-8){sh[7]}}, sh[7:0]};
            3'b001:  res = {{(n-16){sh[15]}}, sh[15:0]};
            3'b010:  res = sh;
            3'b100:  res = {{(n-8){1'b0}}, sh[7:0]};
            3'b101:  res = {{(n-16){1'b0}}, sh[15:0]};
            default: res = {n{1'b0}};
        endcase
        return res;
    endfunction

    // Merge store data into the old word, preserving unaddressed lanes.
    function automatic logic [n-1:0] store_merge(input logic [n-1:0] old,
                                                 input logic [n-1:0] data,
                                                 input logic [1:0] lane,
                                                 input logic [2:0] f3);
        logic [n-1:0] mask;
        case (f3)
            3'b000:  mask = {{(n-8){1'b0}}, 8'hFF};
            3'b001:  mask = {{(n-16){1'b0}}, 16'hFFFF};
            default: mask = {n{1'b1}};
        endcase
        return (old & ~(mask << {lane, 3'b000})) | ((data & mask) << {lane, 3'b000});
    endfunction

    assign idx_s         = addr_r[AW+1:2];
    assign addr_unused_s = addr_r[n-1:AW+2];
    assign fault_s       = access_fault(we_r, f3_r, addr_r[1:0]);
    assign word_s        = mem_r[idx_s];

    // FSM state and wait counter register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // FSM next state: accept in IDLE, count wait states, single RESP cycle.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        accept_s    = 1'b0;
        commit_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.req) begin
                    accept_s    = 1'b1;
                    cnt_nxt_s   = 4'd0;
                    state_nxt_s = HAS_WAIT ? ST_WAIT : ST_RESP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == WAIT_LAST) begin
                    cnt_nxt_s   = 4'd0;
                    state_nxt_s = ST_RESP;
                end else begin
                    cnt_nxt_s   = cnt_r + 4'd1;
                end
            end
            ST_RESP: begin
                commit_s    = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Request capture at accept; later input changes are ignored.
    always_ff @(posedge clock) begin
        if (!reset) begin
            we_r    <= 1'b0;
            f3_r    <= 3'b000;
            addr_r  <= {n{1'b0}};
            wdata_r <= {n{1'b0}};
        end else if (accept_s) begin
            we_r    <= bus.we;
            f3_r    <= bus.funct3;
            addr_r  <= bus.addr;
            wdata_r <= bus.wdata;
        end else begin
            we_r    <= we_r;
            f3_r    <= f3_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

    // Storage write; deliberately not cleared by reset, and blocked by it.
    always_ff @(posedge clock) begin
        if (reset && commit_s && we_r && !fault_s) begin
            mem_r[idx_s] <= store_merge(word_s, wdata_r, addr_r[1:0], f3_r);
        end
    end

    // Registered response outputs; rdata/err are zero outside the ready pulse.
    always_ff @(posedge clock) begin
        if (!reset) begin
            busy_r  <= 1'b0;
            ready_r <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= {n{1'b0}};
        end else begin
            busy_r <= (state_nxt_s != ST_IDLE);
            if (commit_s) begin
                ready_r <= 1'b1;
                err_r   <= fault_s;
                rdata_r <= (fault_s || we_r) ? {n{1'b0}}
                                             : load_ext(word_s, addr_r[1:0], f3_r);
            end else begin
                ready_r <= 1'b0;
                err_r   <= 1'b0;
                rdata_r <= {n{1'b0}};
            end
        end
    end

    assign bus.busy  = busy_r;
    assign bus.ready = ready_r;
    assign bus.err   = err_r;
    assign bus.rdata = rdata_r;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder with WAIT=2, DEPTH=256.
module tb_dmem_responder;
    localparam int WAIT = 2;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    dmem_responder_if #(.n(32)) bus ();

    dmem_responder #(.n(32), .DEPTH(256), .WAIT(WAIT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t vecs [16] = '{
        '{1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0},
        '{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0},
        '{1'b1, 3'b000, 32'h11,  32'h80,       32'h0,        1'b0},
        '{1'b0, 3'b000, 32'h11,  32'h0,        32'hFFFFFF80, 1'b0},
        '{1'b0, 3'b100, 32'h11,  32'h0,        32'h00000080, 1'b0},
        '{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEAD80EF, 1'b0},
        '{1'b0, 3'b001, 32'h12,  32'h0,        32'hFFFFDEAD, 1'b0},
        '{1'b0, 3'b101, 32'h12,  32'h0,        32'h0000DEAD, 1'b0},
        '{1'b0, 3'b010, 32'h12,  32'h0,        32'h0,        1'b1},
        '{1'b1, 3'b001, 32'h13,  32'h5555,     32'h0,        1'b1},
        '{1'b0, 3'b011, 32'h10,  32'h0,        32'h0,        1'b1},
        '{1'b1, 3'b100, 32'h10,  32'h77,       32'h0,        1'b1},
        '{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEAD80EF, 1'b0},
        '{1'b0, 3'b010, 32'h410, 32'h0,        32'hDEAD80EF, 1'b0},
        '{1'b1, 3'b010, 32'h20,  32'hCAFEF00D, 32'h0,        1'b0},
        '{1'b1, 3'b010, 32'h30,  32'h55AA55AA, 32'h0,        1'b0}
    };

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One request; returns the response and the number of edges after the accept edge.
    task automatic txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output logic e,
                       output int lat);
        int  n_edges;
        logic got;
        @(negedge clock);
        bus.req    = 1'b1;
        bus.we     = w;
        bus.funct3 = f3;
        bus.addr   = a;
        bus.wdata  = d;
        got     = 1'b0;
        n_edges = 0;
        while (!got && n_edges < 40) begin
            @(posedge clock);
            n_edges++;
            @(negedge clock);
            if (bus.ready === 1'b1) got = 1'b1;
        end
        bus.req = 1'b0;
        check("ready_seen", {31'd0, got}, 32'd1);
        rd  = bus.rdata;
        e   = bus.err;
        lat = n_edges - 1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat;
        logic        seen;
        checks   = 0;
        failures = 0;

        // Reset held with req asserted
        reset      = 1'b0;
        bus.req    = 1'b1;
        bus.we     = 1'b1;
        bus.funct3 = 3'b010;
        bus.addr   = 32'h10;
        bus.wdata  = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            @(negedge clock);
            check("rst_busy",  {31'd0, bus.busy},  32'd0);
            check("rst_ready", {31'd0, bus.ready}, 32'd0);
            check("rst_err",   {31'd0, bus.err},   32'd0);
            check("rst_rdata", bus.rdata,          32'd0);
        end
        bus.req = 1'b0;
        reset   = 1'b1;

        // Directed vector table: data, lanes, faults, alias
        for (int i = 0; i < 16; i++) begin
            txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, e, lat);
            check($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
            check($sformatf("v%0d_err", i), {31'd0, e}, {31'd0, vecs[i].err});
            check($sformatf("v%0d_lat", i), lat, WAIT + 1);
        end

        // Second request pulsed during WAIT and RESP must be ignored
        @(negedge clock);
        bus.req    = 1'b1;
        bus.we     = 1'b0;
        bus.funct3 = 3'b010;
        bus.addr   = 32'h10;
        bus.wdata  = 32'h0;
        @(posedge clock);
        @(negedge clock);
        check("busy_wait", {31'd0, bus.busy}, 32'd1);
        bus.we    = 1'b1;
        bus.addr  = 32'h20;
        bus.wdata = 32'h11111111;
        @(posedge clock);
        @(negedge clock);
        @(posedge clock);
        @(negedge clock);
        check("busy_resp",  {31'd0, bus.busy},  32'd1);
        check("resp_noready", {31'd0, bus.ready}, 32'd0);
        @(posedge clock);
        @(negedge clock);
        bus.req = 1'b0;
        check("busy_ready", {31'd0, bus.ready}, 32'd1);
        check("busy_rdata", bus.rdata, 32'hDEAD80EF);
        @(posedge clock);
        @(negedge clock);
        check("after_ready", {31'd0, bus.ready}, 32'd0);
        check("after_rdata", bus.rdata, 32'd0);
        check("after_busy",  {31'd0, bus.busy},  32'd0);
        txn(1'b0, 3'b010, 32'h20, 32'h0, rd, e, lat);
        check("busy_keep20", rd, 32'hCAFEF00D);

        // Reset during WAIT aborts the store without a ready pulse
        @(negedge clock);
        bus.req    = 1'b1;
        bus.we     = 1'b1;
        bus.funct3 = 3'b010;
        bus.addr   = 32'h30;
        bus.wdata  = 32'h00001234;
        @(posedge clock);
        @(negedge clock);
        bus.req = 1'b0;
        reset   = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (bus.ready !== 1'b0) seen = 1'b1;
        end
        check("midrst_noready", {31'd0, seen}, 32'd0);
        txn(1'b0, 3'b010, 32'h30, 32'h0, rd, e, lat);
        check("midrst_keep30", rd, 32'h55AA55AA);
        check("midrst_err", {31'd0, e}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
